// File: rtl/instr_rom_loader.sv
// Loadable instruction RAM answering CPU fetches, with a load/reset/run/halt
// sequencer that holds the CPU in reset while a program is streamed in.
module instr_rom_loader #(
    parameter int unsigned DEPTH        = 256,
    parameter logic [31:0] BASE_ADDR    = 32'hBFC00000,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_reset,
    output logic        cpu_clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic        cpu_active,
    input  logic [31:0] register_v0,
    output logic        done,
    output logic        timeout,
    output logic        overflow,
    output logic [31:0] result,
    output logic [31:0] cycle_count
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [31:0] SPAN_C  = 32'(DEPTH * 4);
    localparam logic [31:0] TMO_C   = 32'(MAX_CYCLES - 1);
    localparam logic [31:0] PULSE_C = 32'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PULSE, S_RUN, S_HALT} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW:0]   r_idx;
    logic [31:0]   r_pulse_cnt;
    logic          r_done, r_timeout, r_overflow;
    logic [31:0]   r_result, r_cycle_count;
    logic [31:0]   r_mem [DEPTH];

    logic          w_ready, w_accept, w_start, w_we, w_halt, w_tmo, w_hit;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_off;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_HALT);
    assign w_accept = load_valid && w_ready;
    // IDLE and HALT both start a fresh program at word 0
    assign w_start  = w_accept && (r_state != S_LOAD);
    assign w_we     = w_accept && (w_start || (r_idx < DEPTH_C));
    assign w_waddr  = w_start ? '0 : r_idx[AW-1:0];
    assign w_halt   = (instr_address == 32'h0) || !cpu_active;
    assign w_tmo    = (r_cycle_count == TMO_C);

    always_comb begin
        w_state_nxt    = r_state;
        cpu_reset      = 1'b1;
        cpu_clk_enable = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                cpu_reset = (r_state == S_IDLE);
                if (w_accept) w_state_nxt = load_last ? S_PULSE : S_LOAD;
            end
            S_LOAD: begin
                if (w_accept && load_last) w_state_nxt = S_PULSE;
            end
            S_PULSE: begin
                cpu_clk_enable = 1'b1;
                if (r_pulse_cnt == PULSE_C) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                cpu_reset      = 1'b0;
                cpu_clk_enable = 1'b1;
                if (w_halt || w_tmo) w_state_nxt = S_HALT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_pulse_cnt   <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_overflow    <= 1'b0;
            r_result      <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pulse_cnt <= (r_state == S_PULSE) ? r_pulse_cnt + 32'd1 : 32'd0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (w_accept) begin
                        r_idx         <= (AW+1)'(1);
                        r_done        <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_cycle_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_idx < DEPTH_C) r_idx      <= r_idx + 1'b1;
                        else                 r_overflow <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_cycle_count <= r_cycle_count + 32'd1;
                    if (w_halt || w_tmo) begin
                        r_done    <= 1'b1;
                        r_result  <= register_v0;
                        // a real halt on the timeout cycle is not a timeout
                        r_timeout <= !w_halt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= load_data;
    end

    assign w_off          = instr_address - BASE_ADDR;
    assign w_hit          = (instr_address[1:0] == 2'b00) && (instr_address >= BASE_ADDR) &&
                            (w_off < SPAN_C);
    assign instr_readdata = w_hit ? r_mem[w_off[AW+1:2]] : 32'h0;

    assign load_ready  = w_ready;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign overflow    = r_overflow;
    assign result      = r_result;
    assign cycle_count = r_cycle_count;
endmodule

// File: tb/tb_instr_rom_loader.sv
// Bench for instr_rom_loader: behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomized load/fetch/halt traffic.
module tb_instr_rom_loader;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          RCYC  = 2;
    localparam int          MAXC  = 50;

    logic        clk = 0, reset_n;
    logic        load_valid, load_last, load_ready;
    logic [31:0] load_data;
    logic        cpu_reset, cpu_clk_enable, cpu_active;
    logic [31:0] instr_address, instr_readdata, register_v0;
    logic        done, timeout, overflow;
    logic [31:0] result, cycle_count;

    instr_rom_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RESET_CYCLES(RCYC), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .cpu_reset(cpu_reset), .cpu_clk_enable(cpu_clk_enable),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .cpu_active(cpu_active), .register_v0(register_v0),
        .done(done), .timeout(timeout), .overflow(overflow),
        .result(result), .cycle_count(cycle_count));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    int          m_pulse, m_wi, m_cyc;
    bit          m_running, m_halted, m_loading;
    bit          m_done, m_tmo, m_ovf, m_acc, m_stop;
    logic [31:0] m_res;

    function automatic bit m_ready();
        return !(m_pulse > 0 || m_running);
    endfunction

    function automatic bit fetch_exp(input logic [31:0] a, output logic [31:0] d);
        longint off;
        off = longint'(a) - longint'(BASE);
        d = 32'h0;
        if (a[1:0] != 2'b00 || off < 0 || off / 4 >= DEPTH) return 1'b1;
        if (!m_wr[off/4]) return 1'b0;
        d = m_mem[off/4];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pulse = 0; m_wi = 0; m_cyc = 0;
            m_running = 0; m_halted = 0; m_loading = 0;
            m_done = 0; m_tmo = 0; m_ovf = 0; m_res = 0;
            for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
        end else begin
            m_acc = load_valid && m_ready();
            if (m_pulse > 0) begin
                m_pulse--;
                if (m_pulse == 0) m_running = 1;
            end else if (m_running) begin
                m_cyc++;
                m_stop = (instr_address == 0) || !cpu_active;
                if (m_stop || m_cyc == MAXC) begin
                    m_running = 0; m_halted = 1; m_done = 1;
                    m_res = register_v0; m_tmo = !m_stop;
                end
            end else if (m_acc) begin
                if (!m_loading) begin
                    m_wi = 0; m_done = 0; m_tmo = 0; m_ovf = 0; m_cyc = 0; m_halted = 0;
                end
                if (m_wi < DEPTH) begin
                    m_mem[m_wi] = load_data; m_wr[m_wi] = 1; m_wi++;
                end else m_ovf = 1;
                m_loading = 1;
                if (load_last) begin
                    m_loading = 0; m_pulse = RCYC;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] d;
        chk("load_ready", load_ready, m_ready());
        chk("cpu_reset", cpu_reset, !(m_running || m_halted));
        chk("cpu_clk_enable", cpu_clk_enable, (m_pulse > 0) || m_running);
        chk("done", done, m_done);
        chk("timeout", timeout, m_tmo);
        chk("overflow", overflow, m_ovf);
        chk("result", result, m_res);
        chk("cycle_count", cycle_count, m_cyc);
        if (fetch_exp(instr_address, d)) chk("instr_readdata", instr_readdata, d);
    end

    // ---------------- stimulus ----------------
    logic [31:0] prog [16];

    task automatic cyc();
        @(negedge clk); #2;
    endtask

    task automatic send(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            load_valid = 1; load_data = prog[i]; load_last = last && (i == n - 1);
            chk("ready_while_loading", load_ready, 1);
            cyc();
        end
        load_valid = 0; load_last = 0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!(cpu_reset == 0 && cpu_clk_enable == 1) && n < 20) begin cyc(); n++; end
        chk("run_reached", n < 20, 1);
    endtask

    task automatic halt_now();
        instr_address = 32'h0; cyc(); instr_address = BASE;
        chk("halt_done", done, 1);
    endtask

    initial begin
        int n, r;
        reset_n = 0; load_valid = 0; load_last = 0; load_data = 0;
        instr_address = BASE; cpu_active = 1; register_v0 = 0;
        repeat (2) cyc();
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_clk_en", cpu_clk_enable, 0);
        chk("rst_done", done, 0);
        chk("rst_count", cycle_count, 0);
        reset_n = 1; cyc();

        // addiu $2,$0,5 ; jr $0 ; nop ; nop
        prog[0] = 32'h24020005; prog[1] = 32'h00000008; prog[2] = 0; prog[3] = 0;
        send(4, 1);
        n = 0;
        while (cpu_reset && cpu_clk_enable && n < 10) begin n++; cyc(); end
        chk("pulse_len", n, 2);
        instr_address = BASE + 4; #1;
        chk("fetch_jr", instr_readdata, 32'h00000008);
        register_v0 = 5; cyc();
        halt_now();
        chk("t1_result", result, 5);
        chk("t1_timeout", timeout, 0);
        chk("t1_cycles", cycle_count, 2);

        instr_address = BASE; #1;              chk("fetch_w0", instr_readdata, 32'h24020005);
        instr_address = BASE + 4 * DEPTH; #1;  chk("fetch_past_end", instr_readdata, 0);
        instr_address = 32'h00000010; #1;      chk("fetch_low", instr_readdata, 0);
        instr_address = BASE + 2; #1;          chk("fetch_misalign", instr_readdata, 0);
        instr_address = BASE; cyc();

        for (int i = 0; i < DEPTH + 3; i++) prog[i] = 32'hA0000000 + i;
        send(DEPTH + 3, 1);
        chk("ovf_set", overflow, 1);
        instr_address = BASE + 4 * (DEPTH - 1); #1;
        chk("ovf_last_word", instr_readdata, 32'hA0000000 + DEPTH - 1);
        instr_address = BASE;
        wait_run();
        register_v0 = 32'hCAFE0001; cpu_active = 0; cyc(); cpu_active = 1;
        chk("inactive_halt", done, 1);
        chk("inactive_result", result, 32'hCAFE0001);

        prog[0] = 32'h0;
        send(1, 1);
        chk("reload_done_clr", done, 0);
        chk("reload_ovf_clr", overflow, 0);
        chk("reload_cnt_clr", cycle_count, 0);
        chk("reload_pulse", {cpu_reset, cpu_clk_enable}, 2'b11);
        wait_run();
        halt_now();

        prog[0] = 32'h1000FFFF;                // b .
        send(1, 1);
        wait_run();
        register_v0 = 32'h1234; n = 0;
        while (!done && n < 200) begin cyc(); n++; end
        chk("tmo_run_cycles", n, 50);
        chk("tmo_flag", timeout, 1);
        chk("tmo_count", cycle_count, 50);
        chk("tmo_result", result, 32'h1234);

        for (int i = 0; i < 5; i++) prog[i] = 32'h11110000 + i;
        send(2, 0);
        reset_n = 0; #1;
        chk("mid_rst_cpu_reset", cpu_reset, 1);
        chk("mid_rst_ready", load_ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_timeout", timeout, 0);
        cyc(); reset_n = 1; cyc();
        send(5, 1);
        wait_run();
        register_v0 = 7; halt_now();
        chk("reload_result", result, 7);

        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 499) == 0) begin reset_n = 0; cyc(); reset_n = 1; end
            load_valid = ($urandom_range(0, 9) < 6);
            load_data  = $urandom;
            load_last  = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 99);
            if (r < 5)       instr_address = 32'h0;
            else if (r < 15) instr_address = BASE + 4 * $urandom_range(0, DEPTH - 1) + 2;
            else if (r < 25) instr_address = 32'h10;
            else if (r < 30) instr_address = BASE + 4 * (DEPTH + $urandom_range(0, 3));
            else             instr_address = BASE + 4 * $urandom_range(0, DEPTH - 1);
            cpu_active  = ($urandom_range(0, 99) != 0);
            register_v0 = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_rom_loader.md
Name: instr_rom_loader

Overview:
- Responder side of the CPU instruction-fetch interface: a loadable instruction RAM that answers `mips_cpu_harvard` fetches.
- A sequencer loads a program word-by-word, holds the CPU in reset during loading, then releases it.
- Detects the halt fetch (`instr_address == 0`), captures `register_v0` and freezes the CPU.
- Used by benches and FPGA wrappers in place of hand-coded per-address instruction decode.

Parameters:
- DEPTH, 256, instruction words stored (power of two, ≥ 4).
- BASE_ADDR, 32'hBFC00000, byte address of word 0 (reset vector).
- RESET_CYCLES, 2, cycles `cpu_reset` stays high after load completes.
- MAX_CYCLES, 1000, RUN cycles allowed before forced halt with timeout.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  load word present.
- load_data  in  32  instruction word to store.
- load_last  in  1  qualifies final word of program.
- load_ready  out  1  loader accepts word this cycle.
- cpu_reset  out  1  drives CPU reset (active-high).
- cpu_clk_enable  out  1  drives CPU clk_enable.
- instr_address  in  32  CPU fetch byte address.
- instr_readdata  out  32  fetched instruction.
- cpu_active  in  1  CPU active flag.
- register_v0  in  32  CPU $v0 value.
- done  out  1  program halted normally or by timeout.
- timeout  out  1  halt was forced by MAX_CYCLES.
- overflow  out  1  program exceeded DEPTH; excess words dropped.
- result  out  32  `register_v0` captured at halt.
- cycle_count  out  32  CPU cycles spent in RUN.

Behaviour:
- Reset (`reset_n` low, async), all values:
  - state = IDLE, write index = 0.
  - `cpu_reset` = 1, `cpu_clk_enable` = 0.
  - `done` = `timeout` = `overflow` = 0, `result` = 0, `cycle_count` = 0.
  - RAM contents undefined.
- Fetch path, combinational:
  - `idx = (instr_address - BASE_ADDR) >> 2`.
  - If `instr_address` is word-aligned, `≥ BASE_ADDR` and `idx < DEPTH`: `instr_readdata = mem[idx]`.
  - Otherwise `instr_readdata = 0` (NOP), including address 0.
  - Zero latency in every state.
- `load_ready` = 1 in IDLE, LOAD and HALT; 0 in PULSE and RUN. A word is accepted on a cycle with `load_valid && load_ready`.
- IDLE:
  - On accept: write `mem[0]`, index = 1, clear `done`/`timeout`/`overflow`/`cycle_count`.
  - If `load_last` is set, go to PULSE; else go to LOAD.
- LOAD:
  - Each accept writes `mem[index]` and increments index.
  - If `index ≥ DEPTH`: word dropped, `overflow` = 1 (sticky until next load starts), index saturates.
  - Accept with `load_last` goes to PULSE. No timeout while waiting for words.
- PULSE:
  - `cpu_reset` = 1, `cpu_clk_enable` = 1 for exactly RESET_CYCLES cycles (CPU samples reset on its edge).
  - Then go to RUN.
- RUN:
  - `cpu_reset` = 0, `cpu_clk_enable` = 1, `cycle_count` increments every cycle.
  - Halt condition: `instr_address == 0` sampled at posedge, or `cpu_active` == 0 sampled at posedge.
  - On halt: go to HALT, `result` <= `register_v0` on the same edge, `done` = 1.
  - If `cycle_count == MAX_CYCLES-1` with no halt: go to HALT, `timeout` = 1, `done` = 1, `result` still captured.
  - If halt and timeout coincide, the halt wins: `timeout` = 0.
- HALT:
  - `cpu_clk_enable` = 0, `cpu_reset` = 0; outputs held.
  - An accept here behaves exactly as an accept in IDLE (new program from index 0, old contents overwritten as written).
- `reset_n` low in any state returns to the reset values immediately. A load interrupted mid-program must be resent whole.
- `cycle_count` does not wrap before MAX_CYCLES; widths are fixed at 32.

Test Plan:
- Load 4 words (`addiu $2,$0,5`; `jr $0`; nop; nop, last on word 3) → `load_ready` high throughout; PULSE lasts 2 cycles; in RUN, fetch at BFC00004 returns the jr word; `done` = 1, `result` = 5, `timeout` = 0.
- Fetch BFC00000+4·DEPTH, fetch 0x00000010, and fetch BFC00002 (misaligned) → each returns 32'h0.
- Send DEPTH+3 words → `overflow` = 1; `mem[DEPTH-1]` holds word DEPTH-1; CPU still released afterwards.
- Program `b .` (infinite loop) with MAX_CYCLES = 50 → HALT after exactly 50 RUN cycles, `timeout` = 1, `done` = 1, `cycle_count` = 50.
- From HALT, load a new single-word program with `load_last` → `done`/`timeout`/`overflow` cleared on the accept, PULSE then RUN repeat.
- Drop `reset_n` mid-LOAD (after 2 of 5 words) → `cpu_reset` = 1, `load_ready` = 1, state IDLE; full reload then completes normally.
